bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have port clk, input, 1: single clock domain, all state on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: request conversion of bin_in; accepted only when ready=1.
REQ-004 SHALL have port bin_in, input, 32: unsigned binary value, sampled on the accepting edge only.
REQ-005 SHALL have port ready, output, 1: high only in IDLE.
REQ-006 SHALL have port bcd_out, output, 32: 8 packed BCD digits, digit0 in [3:0], digit7 in [31:28], held between conversions.
REQ-007 SHALL have port ovf, output, 1: value exceeded 99,999,999; held with bcd_out.
REQ-008 SHALL have port out_valid, output, 1: one-cycle pulse when bcd_out/ovf update.

Function
REQ-009 SHALL implement sequential double-dabble: 32-bit shift register plus 40-bit (10-digit) BCD accumulator.
REQ-010 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start&ready; SHIFT->DONE after 32nd shift; DONE->IDLE unconditionally.
REQ-011 SHALL, on accepting edge E0, load bin_in, clear accumulator and 5-bit shift counter.
REQ-012 SHALL, on each SHIFT edge E1..E32, add 3 to every accumulator digit >=5, then shift left one bit, MSB of binary entering accumulator bit 0.
REQ-013 SHALL, on edge E33 (in DONE), register bcd_out = accumulator[31:0], ovf = |accumulator[39:32], out_valid=1.
REQ-014 SHALL give latency of exactly 33 clock edges from accepting edge to the edge raising out_valid.
REQ-015 SHALL deassert out_valid on the next edge; it never exceeds one cycle.
REQ-016 SHALL ignore start while ready=0; bin_in changes during conversion have no effect.
REQ-017 SHALL accept start in the same cycle out_valid is high (back-to-back, one conversion every 34 cycles).
REQ-018 SHALL leave bcd_out/ovf unchanged from E0 through E32.
REQ-019 SHALL wrap: results above 99,999,999 output low 8 digits (value mod 10^8) with ovf=1.

Reset
REQ-020 SHALL, on rst assertion at any time including mid-SHIFT, asynchronously force state IDLE, counter 0, accumulator 0, bcd_out 0, ovf 0, out_valid 0, ready 1 after release.
REQ-021 SHALL discard any in-flight conversion on reset; no out_valid follows.

Configuration
REQ-022 SHALL support macro BCD_LEADING_BLANK_EN.
REQ-023 With BCD_LEADING_BLANK_EN defined: at E33, each leading zero digit from digit7 downward to the first nonzero digit SHALL be replaced by 4'hF (blank code); digit0 never blanked; ovf=1 disables blanking.
REQ-024 Without BCD_LEADING_BLANK_EN: bcd_out SHALL carry raw digits including leading zeros; no blanking logic synthesised.

Structure
REQ-025 SHALL place in shared package bcd_pkg: BIN_W=32, DIGITS=8, ACC_DIGITS=10, BLANK_CODE=4'hF, FSM state enum type.
REQ-026 SHALL instantiate sub-module bcd_add3 (4-bit combinational digit >=5 ? +3 : pass) once per accumulator digit (10 instances).

Verification
REQ-027 bin_in=0, start -> after 33 edges out_valid=1, bcd_out=0x00000000, ovf=0 (blank build: 0xFFFFFFF0).
REQ-028 bin_in=12345678 -> bcd_out=0x12345678, ovf=0; bin_in=1234 blank build -> 0xFFFF1234.
REQ-029 bin_in=99999999 -> 0x99999999, ovf=0; bin_in=100000000 -> 0x00000000, ovf=1; bin_in=0xFFFFFFFF -> 0x94967295, ovf=1.
REQ-030 start pulsed at E10 during conversion with different bin_in -> ignored, first result unchanged, exactly one out_valid.
REQ-031 rst asserted at E16 mid-SHIFT -> outputs zero immediately, ready=1 after release, no out_valid; new start converts correctly.
REQ-032 start held high continuously with values 5, 42 -> out_valid pulses 34 cycles apart, bcd_out 0x00000005 then 0x00000042.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, blank code and FSM state type for the BCD converter
package bcd_pkg;

    localparam int BIN_W      = 32;
    localparam int DIGITS     = 8;
    localparam int ACC_DIGITS = 10;
    localparam int ACC_W      = ACC_DIGITS * 4;
    localparam int OUT_W      = DIGITS * 4;
    localparam int CNT_W      = 5;

    // Digit code shown in place of a suppressed leading zero.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: digit >= 5 ? digit + 3 : digit
//
// Ports:
//   din  - one BCD accumulator digit
//   dout - corrected digit, ready to be shifted left
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential 32-bit binary to 8-digit packed BCD converter
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - asynchronous active-high reset
//   start     - conversion request, taken only while ready is high
//   bin_in    - unsigned binary operand, sampled on the accepting edge
//   ready     - high while idle
//   bcd_out   - 8 packed BCD digits, digit0 in [3:0]; held between conversions
//   ovf       - result exceeded 99,999,999 (bcd_out holds value mod 10^8)
//   out_valid - one-cycle pulse when bcd_out/ovf update
//
// Build option: define BCD_LEADING_BLANK_EN to replace leading zero digits
// (digit7 down to, but excluding, digit0) with the blank code when ovf is clear.
module bcd_converter
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin_in,
    output logic               ready,
    output logic [OUT_W-1:0]   bcd_out,
    output logic               ovf,
    output logic               out_valid
);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               acc_ovf;
    logic [OUT_W-1:0]   bcd_fmt;

    for (genvar i = 0; i < ACC_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[4*i +: 4]),
            .dout (acc_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready   = (state == IDLE);
    assign acc_ovf = |acc[ACC_W-1:OUT_W];

`ifdef BCD_LEADING_BLANK_EN
    // Blank from the top digit down while digits stay zero; an overflowed
    // result is shown raw so the wrapped value is not misread.
    always_comb begin
        logic leading;
        bcd_fmt = acc[OUT_W-1:0];
        leading = !acc_ovf;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && (acc[4*i +: 4] == 4'd0)) begin
                bcd_fmt[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign bcd_fmt = acc[OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bin_in;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Correct every digit first, then shift the next binary MSB in.
                    acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd_out   <= bcd_fmt;
                    ovf       <= acc_ovf;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// tb/tb_bcd_converter.sv - self-checking bench for bcd_converter
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin_in = '0;
    logic        ready;
    logic [31:0] bcd_out;
    logic        ovf;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (bin_in),
        .ready     (ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

`ifdef BCD_LEADING_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // Reference: decimal arithmetic on the integer value.
    function automatic logic [32:0] model(input logic [31:0] v);
        longint unsigned x;
        longint unsigned r;
        logic [31:0]     b;
        logic            o;
        bit              lead;
        x = longint'(v);
        o = (x > 64'd99999999);
        r = x % 64'd100000000;
        b = '0;
        for (int d = 0; d < 8; d++) begin
            b[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
        if (BLANK && !o) begin
            lead = 1'b1;
            for (int d = 7; d > 0; d--) begin
                if (lead && b[4*d +: 4] == 4'd0) b[4*d +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
        return {o, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_ready_timeout"}, 64'(ready), 64'd1);
    endtask

    // One full conversion: latency, held outputs, result, single-cycle pulse.
    task automatic convert(input string tag, input logic [31:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int          n;
        logic [31:0] hold_bcd;
        logic        hold_ovf;
        bit          changed;
        wait_ready(tag);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        hold_bcd = bcd_out;
        hold_ovf = ovf;
        tick();
        start  = 1'b0;
        bin_in = $urandom;
        n = 0;
        changed = 1'b0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (bcd_out !== hold_bcd || ovf !== hold_ovf) changed = 1'b1;
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_held"}, 64'(changed), 64'd0);
        check({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        tick();
        check({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
    endtask

    task automatic convert_model(input string tag, input logic [31:0] v);
        logic [32:0] m;
        m = model(v);
        convert(tag, v, m[31:0], m[32]);
    endtask

    initial begin
        int          n;
        int          pulses;
        int          t1;
        int          t2;
        logic [31:0] first_bcd;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_bcd", 64'(bcd_out), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;

        // Directed values with constant expectations.
        convert("zero", 32'd0, BLANK ? 32'hFFFFFFF0 : 32'h00000000, 1'b0);
        convert("d12345678", 32'd12345678, 32'h12345678, 1'b0);
        convert("d99999999", 32'd99999999, 32'h99999999, 1'b0);
        convert("d100000000", 32'd100000000, 32'h00000000, 1'b1);
        convert("d1234", 32'd1234, BLANK ? 32'hFFFF1234 : 32'h00001234, 1'b0);
        convert("max", 32'hFFFFFFFF, 32'h94967295, 1'b1);

        // Random values against the arithmetic model.
        for (int i = 0; i < 6; i++) convert_model("rnd_full", $urandom);
        for (int i = 0; i < 6; i++) convert_model("rnd_small", 32'($urandom_range(0, 99999999)));
        for (int i = 0; i < 3; i++) convert_model("rnd_tiny", 32'($urandom_range(0, 999)));

        // A start presented at E10 during a conversion must be ignored.
        v = 32'($urandom_range(1, 99999999));
        wait_ready("ignore");
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        tick();
        start  = 1'b0;
        n = 0; pulses = 0; t1 = -1; first_bcd = '0;
        while (n < 45) begin
            if (n == 9)  begin start = 1'b1; bin_in = v ^ 32'h00ABCDEF; end
            if (n == 10) start = 1'b0;
            tick();
            n++;
            if (out_valid === 1'b1) begin
                pulses++;
                if (t1 < 0) begin t1 = n; first_bcd = bcd_out; end
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_latency", 64'(t1), 64'd33);
        check("ignore_bcd", 64'(first_bcd), 64'(model(v)));

        // Reset in the middle of SHIFT discards the conversion.
        wait_ready("midrst");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd87654321;
        tick();
        start = 1'b0;
        repeat (16) tick();
        rst = 1'b1;
        #1;
        check("midrst_bcd", 64'(bcd_out), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_no_valid", 64'(pulses), 64'd0);
        convert_model("after_rst", 32'd777);

        // start held high: back-to-back conversions every 34 cycles.
        wait_ready("b2b");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd5;
        tick();
        bin_in = 32'd42;
        n = 0; t1 = -1; t2 = -1;
        while (n < 80 && t2 < 0) begin
            tick();
            n++;
            if (out_valid === 1'b1) begin
                if (t1 < 0) begin
                    t1 = n;
                    check("b2b_first", 64'(bcd_out), 64'(BLANK ? 32'hFFFFFFF5 : 32'h00000005));
                end else begin
                    t2 = n;
                    check("b2b_second", 64'(bcd_out), 64'(BLANK ? 32'hFFFFFF42 : 32'h00000042));
                end
            end
        end
        start = 1'b0;
        check("b2b_t1", 64'(t1), 64'd33);
        check("b2b_spacing", 64'(t2 - t1), 64'd34);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("b2b_third", 64'(bcd_out), 64'(BLANK ? 32'hFFFFFF42 : 32'h00000042));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
